// File: rtl/serial_seq_tx.sv
// serial_seq_tx: parallel-to-serial bit-stream transmitter.
// Takes a WIDTH-bit word on a load/ready handshake and sends it MSB-first,
// one bit per clock with a qualifying valid, then holds the line idle for
// GAP_CYCLES cycles before the next word can be accepted.
//
// state | meaning
// ------+------------------------------------------------------------
//  00   | IDLE  - line idle, ready for a load
//  01   | SHIFT - one data bit presented per cycle, MSB first
//  10   | GAP   - fixed idle gap after the LSB, load ignored
//  11   | unused encoding, behaves as IDLE and leaves on the next edge

module serial_seq_tx #(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             done,
    output logic [1:0]       state
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_GAP   = 2'b10
    } state_t;

    state_t           st;
    logic [WIDTH-2:0] rest;     // bits still to be sent after the one on x_out
    logic [BW-1:0]    bit_cnt;  // bits remaining after the current one
    logic [GW-1:0]    gap_cnt;  // gap cycles already spent
    logic             done_r;

    // Ready and debug state are pure decodes of the state register; the
    // unused encoding reports ready because it takes the IDLE branch below.
    assign ready = (st != S_SHIFT) && (st != S_GAP);
    assign state = st;
    // Gating with SHIFT keeps done low in any state a glitch could reach.
    assign done  = done_r && (st == S_SHIFT);

    // Sequencer: load capture, MSB-first shifting, gap timing, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_IDLE;
            rest    <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            x_out   <= IDLE_BIT;
            x_valid <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (st)
                S_SHIFT: begin
                    if (bit_cnt != '0) begin
                        x_out   <= rest[WIDTH-2];
                        rest    <= rest << 1;
                        bit_cnt <= bit_cnt - BIT_ONE;
                        done_r  <= (bit_cnt == BIT_ONE);
                    end else begin
                        // LSB has just been presented
                        x_out   <= IDLE_BIT;
                        x_valid <= 1'b0;
                        done_r  <= 1'b0;
                        gap_cnt <= '0;
                        st      <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        st <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_ONE;
                    end
                end
                default: begin
                    // IDLE and the unused encoding share this branch
                    done_r  <= 1'b0;
                    gap_cnt <= '0;
                    if (load) begin
                        rest    <= data_in[WIDTH-2:0];
                        x_out   <= data_in[WIDTH-1];
                        x_valid <= 1'b1;
                        bit_cnt <= BIT_LAST;
                        st      <= S_SHIFT;
                    end else begin
                        x_out   <= IDLE_BIT;
                        x_valid <= 1'b0;
                        st      <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_seq_tx.sv
// Bench for serial_seq_tx: two instances (8-bit/gap 2 and 4-bit/gap 0),
// a frame-position model checked every cycle, plus literal checks of the
// directed scenarios.

module tb_serial_seq_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data_a;
    logic       load_a;
    logic       ready_a, x_out_a, x_valid_a, done_a;
    logic [1:0] state_a;
    logic [3:0] data_b;
    logic       load_b;
    logic       ready_b, x_out_b, x_valid_b, done_b;
    logic [1:0] state_b;

    int n_assert = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    serial_seq_tx #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .load(load_a),
        .ready(ready_a), .x_out(x_out_a), .x_valid(x_valid_a),
        .done(done_a), .state(state_a)
    );

    serial_seq_tx #(.WIDTH(4), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .load(load_b),
        .ready(ready_b), .x_out(x_out_b), .x_valid(x_valid_b),
        .done(done_b), .state(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a frame is w data cycles followed by g gap cycles; pos is the
    // index inside the current frame, -1 when idle.
    int          pos_a = -1;
    logic [31:0] word_a = '0;
    int          pos_b = -1;
    logic [31:0] word_b = '0;

    function automatic logic [5:0] model_out(input int pos, input logic [31:0] word, input int w);
        // {ready, state, x_out, x_valid, done}
        if (pos < 0)       return 6'b1_00_0_0_0;
        else if (pos < w)  return {1'b0, 2'b01, word[w-1-pos], 1'b1, (pos == w-1)};
        else               return 6'b0_10_0_0_0;
    endfunction

    always @(posedge clk) begin
        if (rst) pos_a <= -1;
        else if (pos_a < 0) begin
            if (load_a) begin
                pos_a  <= 0;
                word_a <= {24'd0, data_a};
            end
        end else pos_a <= (pos_a + 1 >= 8 + 2) ? -1 : pos_a + 1;
    end

    always @(posedge clk) begin
        if (rst) pos_b <= -1;
        else if (pos_b < 0) begin
            if (load_b) begin
                pos_b  <= 0;
                word_b <= {28'd0, data_b};
            end
        end else pos_b <= (pos_b + 1 >= 4 + 0) ? -1 : pos_b + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dut_a outputs", {26'd0, ready_a, state_a, x_out_a, x_valid_a, done_a},
                {26'd0, model_out(pos_a, word_a, 8)});
            chk("dut_b outputs", {26'd0, ready_b, state_b, x_out_b, x_valid_b, done_b},
                {26'd0, model_out(pos_b, word_b, 4)});
        end
    end

    // Capture buffers for the directed scenarios, indexed by cycle after t0.
    logic       cap_xo [1:32];
    logic       cap_xv [1:32];
    logic       cap_dn [1:32];
    logic       cap_rd [1:32];
    logic [1:0] cap_st [1:32];

    function automatic logic [31:0] pack(input int sel, input int a, input int b);
        logic [31:0] r;
        r = '0;
        for (int k = a; k <= b; k++) begin
            case (sel)
                0:       r = {r[30:0], cap_xo[k]};
                1:       r = {r[30:0], cap_xv[k]};
                2:       r = {r[30:0], cap_dn[k]};
                default: r = {r[30:0], cap_rd[k]};
            endcase
        end
        return r;
    endfunction

    function automatic int count_gap(input int a, input int b);
        int c;
        c = 0;
        for (int k = a; k <= b; k++) if (cap_st[k] == 2'b10) c++;
        return c;
    endfunction

    // Load d0 at the next edge (t0), then record dut_a for cycles t0+1..t0+n,
    // applying input changes at the listed cycles (0 = never).
    task automatic capture(input int n, input logic [7:0] d0, input logic [7:0] d1,
                           input int k_data, input int k_on, input int k_off, input int k_rst);
        data_a = d0;
        load_a = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= n; k++) begin
            if (k == k_data) data_a = d1;
            if (k == k_on)   load_a = 1'b1;
            if (k == k_off)  load_a = 1'b0;
            if (k == k_rst)  rst = 1'b1;
            if (k_rst != 0 && k == k_rst + 1) rst = 1'b0;
            cap_xo[k] = x_out_a;
            cap_xv[k] = x_valid_a;
            cap_dn[k] = done_a;
            cap_rd[k] = ready_a;
            cap_st[k] = state_a;
            if (k < n) @(negedge clk);
        end
    endtask

    initial begin
        rst    = 1'b1;
        load_a = 1'b0;
        load_b = 1'b0;
        data_a = '0;
        data_b = '0;
        repeat (2) @(negedge clk);

        // Reset
        chk("reset state", {30'd0, state_a}, 32'd0);
        chk("reset ready", {31'd0, ready_a}, 32'd1);
        chk("reset x_out", {31'd0, x_out_a}, 32'd0);
        chk("reset x_valid", {31'd0, x_valid_a}, 32'd0);
        chk("reset done", {31'd0, done_a}, 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Single word A5
        capture(11, 8'hA5, 8'h00, 0, 0, 1, 0);
        chk("A5 stream", pack(0, 1, 8), 32'hA5);
        chk("A5 valid", pack(1, 1, 8), 32'hFF);
        chk("A5 done position", pack(2, 1, 11), 32'h008);
        chk("A5 gap valid", pack(1, 9, 10), 32'd0);
        chk("A5 ready low", pack(3, 1, 10), 32'd0);
        chk("A5 ready again", {31'd0, cap_rd[11]}, 32'd1);

        // Busy load of FF at t0+3 is ignored
        capture(13, 8'hA5, 8'hFF, 3, 3, 4, 0);
        chk("busy stream", pack(0, 1, 8), 32'hA5);
        chk("busy valid pattern", pack(1, 1, 13), 32'h1FE0);
        chk("busy ready low", pack(3, 1, 10), 32'd0);

        // Back-to-back with load held: 3C then C3
        capture(19, 8'h3C, 8'hC3, 1, 0, 12, 0);
        chk("b2b first word", pack(0, 1, 8), 32'h3C);
        chk("b2b second word", pack(0, 12, 19), 32'hC3);
        chk("b2b second MSB at t0+12", pack(1, 9, 12), 32'h1);
        chk("b2b done spacing", pack(2, 1, 19), 32'h00801);
        chk("b2b gap cycles", count_gap(9, 11), 32'd2);
        repeat (3) @(negedge clk);

        // Mid-frame reset at t0+4
        capture(5, 8'hFF, 8'h00, 0, 0, 1, 4);
        chk("midrst no done", pack(2, 1, 5), 32'd0);
        chk("midrst state", {30'd0, cap_st[5]}, 32'd0);
        chk("midrst valid", {31'd0, cap_xv[5]}, 32'd0);
        capture(11, 8'h81, 8'h00, 0, 0, 1, 0);
        chk("after rst stream 81", pack(0, 1, 8), 32'h81);
        chk("after rst done", pack(2, 1, 8), 32'h1);

        // rst and load together: rst wins
        rst    = 1'b1;
        load_a = 1'b1;
        data_a = 8'hFF;
        @(negedge clk);
        rst    = 1'b0;
        load_a = 1'b0;
        chk("rst+load valid", {31'd0, x_valid_a}, 32'd0);
        chk("rst+load ready", {31'd0, ready_a}, 32'd1);
        @(negedge clk);
        chk("rst+load no word", {31'd0, x_valid_a}, 32'd0);

        // 4-bit, zero gap: 1101 then 0110 with load held
        data_b = 4'b1101;
        load_b = 1'b1;
        @(negedge clk);
        data_b = 4'b0110;
        for (int k = 1; k <= 9; k++) begin
            if (k == 6) load_b = 1'b0;
            cap_xo[k] = x_out_b;
            cap_xv[k] = x_valid_b;
            cap_dn[k] = done_b;
            if (k < 9) @(negedge clk);
        end
        chk("w4 stream", pack(0, 1, 9), 32'h1A6);
        chk("w4 valid", pack(1, 1, 9), 32'h1EF);
        chk("w4 done", pack(2, 1, 9), 32'h021);

        // Randomized traffic on both instances
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            load_a = 1'($urandom_range(0, 1));
            data_a = 8'($urandom);
            load_b = 1'($urandom_range(0, 1));
            data_b = 4'($urandom);
            rst    = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        rst    = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
